// File: rtl/elephant_pkg.sv
// rtl/elephant_pkg.sv - shared constants and types for the Elephant pstep2 inverse
//
// Purpose : per-step SWAPMOVE mask, shift and x-rotate constants, step count,
//           and the controller state encoding.
// Ports   : none (package).

package elephant_pkg;

    localparam int PSTEP2_NSTEPS = 7;

    // Indexed by step number k = 0..6.
    localparam logic [31:0] PSTEP2_MASK [PSTEP2_NSTEPS] = '{
        32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_FF00,
        32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000
    };

    localparam logic [4:0] PSTEP2_SHIFT [PSTEP2_NSTEPS] = '{
        5'd8, 5'd16, 5'd24, 5'd8, 5'd24, 5'd16, 5'd8
    };

    // Left-rotate applied to x after the forward SWAPMOVE; 0 means none.
    localparam logic [4:0] PSTEP2_ROT [PSTEP2_NSTEPS] = '{
        5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd16, 5'd24
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pstep2_state_t;

endpackage

// File: rtl/elephant_pstep2_inv_step.sv
// rtl/elephant_pstep2_inv_step.sv - combinational inverse of one pstep2 step
//
// Purpose : undo forward step k: rotate x right by the step's rotate amount,
//           then apply the self-inverse SWAPMOVE with the step's mask/shift.
// Ports   : x, y   - current word pair
//           k      - step index 0..6 (7 yields a pass-through)
//           x_out, y_out - word pair before forward step k

module elephant_pstep2_inv_step
    import elephant_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [2:0]  k,
    output logic [31:0] x_out,
    output logic [31:0] y_out
);

    logic [31:0] m;
    logic [4:0]  n;
    logic [4:0]  r;
    logic [5:0]  r_comp;
    logic [31:0] xr;
    logic [31:0] t;

    // Constant-indexed selection keeps the out-of-range code 7 harmless.
    always_comb begin
        m = '0;
        n = '0;
        r = '0;
        case (k)
            3'd0: begin m = PSTEP2_MASK[0]; n = PSTEP2_SHIFT[0]; r = PSTEP2_ROT[0]; end
            3'd1: begin m = PSTEP2_MASK[1]; n = PSTEP2_SHIFT[1]; r = PSTEP2_ROT[1]; end
            3'd2: begin m = PSTEP2_MASK[2]; n = PSTEP2_SHIFT[2]; r = PSTEP2_ROT[2]; end
            3'd3: begin m = PSTEP2_MASK[3]; n = PSTEP2_SHIFT[3]; r = PSTEP2_ROT[3]; end
            3'd4: begin m = PSTEP2_MASK[4]; n = PSTEP2_SHIFT[4]; r = PSTEP2_ROT[4]; end
            3'd5: begin m = PSTEP2_MASK[5]; n = PSTEP2_SHIFT[5]; r = PSTEP2_ROT[5]; end
            3'd6: begin m = PSTEP2_MASK[6]; n = PSTEP2_SHIFT[6]; r = PSTEP2_ROT[6]; end
            default: ;
        endcase
    end

    // Rotate right by r; when r is 0 the left shift by 32 contributes nothing.
    assign r_comp = 6'd32 - {1'b0, r};
    assign xr     = (x >> r) | (x << r_comp);

    assign t      = (y ^ (xr >> n)) & m;
    assign x_out  = xr ^ (t << n);
    assign y_out  = y ^ t;

endmodule

// File: rtl/elephant_pstep2_inv.sv
// rtl/elephant_pstep2_inv.sv - multi-cycle inverse of the Elephant pstep2 sequence
//
// Purpose : accepts a (x, y, mask) request, undoes each flagged forward step
//           from the highest index down, one step per clock, then presents
//           the recovered pair until the consumer takes it.
// Ports   : g_clk, g_rst           - clock, synchronous active-high reset
//           in_valid/in_ready      - request handshake
//           in_x, in_y, in_mask    - words after the forward sequence, applied steps
//           out_valid/out_ready    - result handshake
//           out_x, out_y           - recovered words (registered)
//           busy                   - high while in RUN or DONE

module elephant_pstep2_inv
    import elephant_pkg::*;
#(
    parameter int NSTEPS = PSTEP2_NSTEPS
) (
    input  logic              g_clk,
    input  logic              g_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_x,
    input  logic [31:0]       in_y,
    input  logic [NSTEPS-1:0] in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_x,
    output logic [31:0]       out_y,
    output logic              busy
);

    pstep2_state_t state, state_nxt;

    logic [31:0]       work_x, work_y;
    logic [NSTEPS-1:0] work_mask;
    logic [NSTEPS-1:0] mask_cleared;
    logic [31:0]       out_x_q, out_y_q;
    logic [2:0]        step_k;
    logic [31:0]       step_x, step_y;

    // Highest set bit of the remaining mask; later forward steps are undone first.
    function automatic logic [2:0] highest_bit(input logic [NSTEPS-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NSTEPS; i++) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign step_k       = highest_bit(work_mask);
    assign mask_cleared = work_mask & ~(NSTEPS'(1) << step_k);

    elephant_pstep2_inv_step u_step (
        .x     (work_x),
        .y     (work_y),
        .k     (step_k),
        .x_out (step_x),
        .y_out (step_y)
    );

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state     <= IDLE;
            work_x    <= '0;
            work_y    <= '0;
            work_mask <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_x    <= in_x;
                        work_y    <= in_y;
                        work_mask <= in_mask;
                        // Empty mask: the request is already the answer.
                        if (in_mask == '0) begin
                            out_x_q <= in_x;
                            out_y_q <= in_y;
                        end
                    end
                end
                RUN: begin
                    work_x    <= step_x;
                    work_y    <= step_y;
                    work_mask <= mask_cleared;
                    if (mask_cleared == '0) begin
                        out_x_q <= step_x;
                        out_y_q <= step_y;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !g_rst;
                if (in_valid) state_nxt = (in_mask == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (mask_cleared == '0) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_x = out_x_q;
    assign out_y = out_y_q;

endmodule

// File: tb/tb_elephant_pstep2_inv.sv
// tb/tb_elephant_pstep2_inv.sv - self-checking bench for elephant_pstep2_inv

module tb_elephant_pstep2_inv;

    logic        g_clk = 1'b0;
    logic        g_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [6:0]  in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 g_clk = ~g_clk;

    elephant_pstep2_inv dut (
        .g_clk     (g_clk),
        .g_rst     (g_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Forward pstep2 sequence straight from the step table, ascending order.
    function automatic void fwd_model(input logic [31:0] x0, input logic [31:0] y0,
                                      input logic [6:0] m,
                                      output logic [31:0] xo, output logic [31:0] yo);
        logic [31:0] x, y, t, msk;
        int n, r;
        x = x0;
        y = y0;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin msk = 32'h000000FF; n = 8;  r = 0;  end
                1: begin msk = 32'h000000FF; n = 16; r = 0;  end
                2: begin msk = 32'h000000FF; n = 24; r = 0;  end
                3: begin msk = 32'h0000FF00; n = 8;  r = 0;  end
                4: begin msk = 32'h000000FF; n = 24; r = 8;  end
                5: begin msk = 32'h0000FF00; n = 16; r = 16; end
                default: begin msk = 32'h00FF0000; n = 8; r = 24; end
            endcase
            if (m[k]) begin
                t = (y ^ (x >> n)) & msk;
                x = x ^ (t << n);
                y = y ^ t;
                if (r != 0) x = (x << r) | (x >> (32 - r));
            end
        end
        xo = x;
        yo = y;
    endfunction

    // Issue one request from posedge+1; return result and edges from accept to out_valid.
    task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [6:0] m,
                           output logic [31:0] ox, output logic [31:0] oy, output int lat);
        int w;
        in_x = x;
        in_y = y;
        in_mask = m;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge g_clk); #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge g_clk); #1;
            lat++;
        end
        ox = out_x;
        oy = out_y;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [6:0]  m;
        logic [31:0] ex;
        logic [31:0] ey;
        int          lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [31:0] ox, oy, hx, hy, rx, ry, fx, fy;
        int lat;

        vecs[0] = '{32'h0000AB00, 32'h0, 7'h01, 32'h0,        32'h000000AB, 2};
        vecs[1] = '{32'h000000CD, 32'h0, 7'h10, 32'h0,        32'h000000CD, 2};
        vecs[2] = '{32'h00AB0000, 32'h0, 7'h11, 32'h0,        32'h000000AB, 3};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 7'h00, 32'h12345678, 32'h9ABCDEF0, 1};

        // Reset
        @(posedge g_clk); #1;
        chk("rst_in_ready_during", 32'(in_ready), 32'd0);
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        #1;
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_y", out_y, 32'd0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].x, vecs[i].y, vecs[i].m, ox, oy, lat);
            chk($sformatf("vec%0d_x", i), ox, vecs[i].ex);
            chk($sformatf("vec%0d_y", i), oy, vecs[i].ey);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            release_out();
            chk($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Back-pressure in DONE, with a competing request that must be ignored
        run_txn(32'h0000AB00, 32'h0, 7'h01, hx, hy, lat);
        chk("hold_first_x", hx, 32'h0);
        chk("hold_first_y", hy, 32'h000000AB);
        in_x = 32'hDEADBEEF;
        in_y = 32'hCAFEF00D;
        in_mask = 7'h7F;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge g_clk); #1;
            chk($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d_x", c), out_x, hx);
            chk($sformatf("hold%0d_y", c), out_y, hy);
        end
        in_valid = 1'b0;
        release_out();
        chk("hold_rel_valid", 32'(out_valid), 32'd0);
        chk("hold_rel_busy", 32'(busy), 32'd0);
        chk("hold_rel_in_ready", 32'(in_ready), 32'd1);

        // Reset during RUN, three steps in
        in_x = 32'h13579BDF;
        in_y = 32'h2468ACE0;
        in_mask = 7'h7F;
        in_valid = 1'b1;
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge g_clk); #1;
        end
        chk("midrun_busy_before", 32'(busy), 32'd1);
        g_rst = 1'b1;
        @(posedge g_clk); #1;
        chk("midrun_rst_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_x", out_x, 32'd0);
        chk("midrun_rst_y", out_y, 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd0);
        g_rst = 1'b0;
        #1;
        chk("midrun_after_in_ready", 32'(in_ready), 32'd1);

        // Round trip over every mask on random pairs
        for (int m = 0; m < 128; m++) begin
            rx = $urandom;
            ry = $urandom;
            fwd_model(rx, ry, 7'(m), fx, fy);
            run_txn(fx, fy, 7'(m), ox, oy, lat);
            chk($sformatf("rand_m%0d_x", m), ox, rx);
            chk($sformatf("rand_m%0d_y", m), oy, ry);
            chk($sformatf("rand_m%0d_lat", m), 32'(lat), 32'($countones(7'(m)) + 1));
            release_out();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
